// File: rtl/sher_vi_mem_sequencer_pkg.sv
// Shared types for the Sher-VI memory sequencer: FSM state encoding and op codes.
package sher_vi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_D = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD1 = 2'd0,
    OP_LOAD2 = 2'd1,
    OP_RMW   = 2'd2,
    OP_STORE = 2'd3
  } op_t;

  localparam int STALL_W = 8;

endpackage

// File: rtl/sher_vi_mem_sequencer_if.sv
// Single-port data memory bus between the sequencer (master) and the memory (slave).
interface sher_vi_mem_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/sher_vi_mem_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module sher_vi_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= {WIDTH{1'b0}};
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/sher_vi_mem_sequencer.sv
// Sequences up to two operand reads and one result write on the shared data memory
// port for one Sher-VI instruction, absorbing wait states and pulsing done at the end.
module sher_vi_mem_sequencer
  import sher_vi_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [ADDR_W-1:0]       addr_a,
  input  logic [ADDR_W-1:0]       addr_b,
  input  logic [ADDR_W-1:0]       addr_d,
  input  logic [DATA_W-1:0]       wdata,
  sher_vi_mem_sequencer_if.master mem,
  output logic [DATA_W-1:0]       opa,
  output logic [DATA_W-1:0]       opb,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              current_state,
  output logic [STALL_W-1:0]      stall_cycles
);
  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_d_q, addr_d_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic              req_s, we_s, stall_clr_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    addr_d_d    = addr_d_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    stall_clr_s = 1'b0;
    req_s       = 1'b0;
    we_s        = 1'b0;
    addr_s      = {ADDR_W{1'b0}};
    wdata_s     = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d        = op_t'(op);
          addr_a_d    = addr_a;
          addr_b_d    = addr_b;
          addr_d_d    = addr_d;
          stall_clr_s = 1'b1;
          state_d     = (op_t'(op) == OP_STORE) ? ST_WR_D : ST_RD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: begin
        req_s  = 1'b1;
        addr_s = addr_a_q;
        if (mem.mem_ready) begin
          opa_d   = mem.mem_rdata;
          state_d = (op_q == OP_LOAD1) ? ST_DONE : ST_RD_B;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_B: begin
        req_s  = 1'b1;
        addr_s = addr_b_q;
        if (mem.mem_ready) begin
          opb_d   = mem.mem_rdata;
          state_d = (op_q == OP_RMW) ? ST_WR_D : ST_DONE;
        end else begin
          state_d = ST_RD_B;
        end
      end
      ST_WR_D: begin
        req_s   = 1'b1;
        we_s    = 1'b1;
        addr_s  = addr_d_q;
        wdata_s = wdata;
        if (mem.mem_ready) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR_D;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      // Encodings 5-7 recover to IDLE on the next edge.
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD1;
      addr_a_q <= {ADDR_W{1'b0}};
      addr_b_q <= {ADDR_W{1'b0}};
      addr_d_q <= {ADDR_W{1'b0}};
      opa_q    <= {DATA_W{1'b0}};
      opb_q    <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_d_q <= addr_d_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  sher_vi_sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
    .clk   (CLK),
    .rst   (Reset),
    .clr   (stall_clr_s),
    .en    (req_s && !mem.mem_ready),
    .count (stall_cycles)
  );

  assign mem.mem_req   = req_s;
  assign mem.mem_we    = we_s;
  assign mem.mem_addr  = addr_s;
  assign mem.mem_wdata = wdata_s;
  assign opa           = opa_q;
  assign opb           = opb_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign current_state = state_q;
endmodule

// File: tb/tb_sher_vi_mem_sequencer.sv
// Self-checking bench for sher_vi_mem_sequencer: vector table plus corner-case sequences.
module tb_sher_vi_mem_sequencer;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] addr_a, addr_b, addr_d;
  logic [31:0] wdata, opa, opb;
  logic        busy, done;
  logic [2:0]  cur_st;
  logic [7:0]  stall;
  logic [31:0] mem_arr [0:255];
  int          n_pass = 0;
  int          n_total = 0;
  logic [2:0]  seq_q[$];

  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_wq[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, d;
    logic [31:0] wd;
    logic [2:0]  sst;
    int          sn;
    logic [31:0] eopa, eopb;
    int          elat;
    logic [7:0]  estall;
  } vec_t;
  vec_t vecs[6];

  sher_vi_mem_sequencer_if #(.ADDR_W(16), .DATA_W(32)) mif();

  sher_vi_mem_sequencer #(.ADDR_W(16), .DATA_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op),
    .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d), .wdata(wdata),
    .mem(mif), .opa(opa), .opb(opb), .busy(busy), .done(done),
    .current_state(cur_st), .stall_cycles(stall)
  );

  always #5 CLK = ~CLK;

  assign mif.mem_rdata = mem_arr[mif.mem_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write scoreboard: each completing write must match the oldest expected write.
  always @(negedge CLK) begin
    #1;
    if (!Reset && mif.mem_req && mif.mem_we && mif.mem_ready) begin
      chk("write_expected", exp_wq.size() != 0, 1);
      if (exp_wq.size() != 0) begin
        wr_t w;
        w = exp_wq.pop_front();
        chk("write_addr", mif.mem_addr, w.addr);
        chk("write_data", mif.mem_wdata, w.data);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic [31:0] wd, input logic [2:0] sst,
                        input int sn, output int lat);
    int e, used;
    bit seen;
    logic [15:0] saddr;
    saddr = (sst == 3'd1) ? a : ((sst == 3'd2) ? b : d);
    if (o == 2'd2 || o == 2'd3) exp_wq.push_back('{addr: d, data: wd});
    @(negedge CLK);
    op = o; addr_a = a; addr_b = b; addr_d = d; wdata = wd; start = 1'b1;
    mif.mem_ready = 1'b1;
    seq_q.delete();
    e = 0; used = 0; seen = 1'b0; lat = -1;
    @(posedge CLK);
    while (!seen && e < 400) begin
      @(negedge CLK);
      start = 1'b0;
      seq_q.push_back(cur_st);
      if (done) seen = 1'b1;
      else begin
        if (cur_st == sst && used < sn) begin
          mif.mem_ready = 1'b0;
          used++;
          chk("stall_hold", {mif.mem_req, mif.mem_we, mif.mem_addr},
              {1'b1, (sst == 3'd3), saddr});
        end else mif.mem_ready = 1'b1;
        @(posedge CLK);
        e++;
      end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      @(posedge CLK);
      lat = e + 1;
    end
    mif.mem_ready = 1'b1;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8'h10] = 32'd7;   mem_arr[8'h14] = 32'd5;
    mem_arr[8'h20] = 32'hdeadbeef;
    mem_arr[8'h24] = 32'h11;  mem_arr[8'h28] = 32'h22;
    mem_arr[8'h34] = 32'h33;  mem_arr[8'h38] = 32'h44;
    mem_arr[8'h40] = 32'h55;  mem_arr[8'h44] = 32'h66;

    vecs[0] = '{2'd2, 16'h10, 16'h14, 16'h18, 32'd12,     3'd0, 0, 32'd7,        32'd5,    4, 8'd0};
    vecs[1] = '{2'd0, 16'h20, 16'h00, 16'h00, 32'd0,      3'd0, 0, 32'hdeadbeef, 32'd5,    2, 8'd0};
    vecs[2] = '{2'd1, 16'h24, 16'h28, 16'h00, 32'd0,      3'd2, 3, 32'h11,       32'h22,   6, 8'd3};
    vecs[3] = '{2'd3, 16'h00, 16'h00, 16'h30, 32'ha5a5,   3'd3, 2, 32'h11,       32'h22,   4, 8'd2};
    vecs[4] = '{2'd2, 16'h34, 16'h38, 16'h3c, 32'h99,     3'd1, 1, 32'h33,       32'h44,   5, 8'd1};
    vecs[5] = '{2'd1, 16'h40, 16'h44, 16'h00, 32'd0,      3'd0, 0, 32'h55,       32'h66,   3, 8'd0};

    Reset = 1'b1; start = 1'b0; op = 2'd0; addr_a = 16'h0; addr_b = 16'h0; addr_d = 16'h0;
    wdata = 32'h0; mif.mem_ready = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("rst_state", cur_st, 3'd0);
    chk("rst_flags", {busy, done, mif.mem_req, mif.mem_we}, 4'b0000);
    chk("rst_addr", mif.mem_addr, 16'h0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);
    chk("rst_ops", {opa, opb}, 64'h0);
    chk("rst_stall", stall, 8'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].wd,
             vecs[i].sst, vecs[i].sn, lat);
      #1;
      chk($sformatf("v%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_opa", i), opa, vecs[i].eopa);
      chk($sformatf("v%0d_opb", i), opb, vecs[i].eopb);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].estall);
      chk($sformatf("v%0d_idle", i), {busy, cur_st}, 4'h0);
      if (i == 0) begin
        chk("rmw_seq_len", seq_q.size(), 4);
        for (int k = 0; k < 4 && k < seq_q.size(); k++)
          chk($sformatf("rmw_seq%0d", k), seq_q[k], k + 1);
      end
    end

    // STORE with start held through WR_D and DONE, then a LOAD1 on the IDLE cycle.
    exp_wq.push_back('{addr: 16'h50, data: 32'h77});
    @(negedge CLK);
    op = 2'd3; addr_d = 16'h50; wdata = 32'h77; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    op = 2'd1;
    chk("st_wr_state", cur_st, 3'd3);
    chk("st_wr_bus", {mif.mem_req, mif.mem_we, mif.mem_addr}, {2'b11, 16'h50});
    @(posedge CLK);
    @(negedge CLK);
    chk("st_done", {done, cur_st}, {1'b1, 3'd4});
    chk("st_done_bus", {mif.mem_req, mif.mem_we, mif.mem_addr}, 18'h0);
    @(posedge CLK);
    @(negedge CLK);
    chk("st_ignored", {busy, cur_st}, 4'h0);
    op = 2'd0; addr_a = 16'h20;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    chk("st_accept", cur_st, 3'd1);
    for (int k = 0; k < 20 && !done; k++) @(negedge CLK);
    chk("st_l1_done", done, 1);
    @(posedge CLK);
    #1;
    chk("st_l1_opa", opa, 32'hdeadbeef);

    // Reset in the middle of an RMW's stalled RD_B: no write may follow.
    @(negedge CLK);
    op = 2'd2; addr_a = 16'h10; addr_b = 16'h14; addr_d = 16'h60; wdata = 32'hbad; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    mif.mem_ready = 1'b0;
    chk("mid_rdb", {mif.mem_req, cur_st}, {1'b1, 3'd2});
    #2 Reset = 1'b1;
    #1;
    chk("async_req", mif.mem_req, 0);
    chk("async_state", {busy, cur_st}, 4'h0);
    chk("async_ops", {opa, opb, stall}, 72'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    mif.mem_ready = 1'b1;
    run_op(2'd0, 16'h20, 16'h0, 16'h0, 32'h0, 3'd0, 0, lat);
    #1;
    chk("post_rst_lat", lat, 2);
    chk("post_rst_ops", {opa, opb}, {32'hdeadbeef, 32'h0});

    // Long stall in RD_A: counter saturates and never wraps.
    run_op(2'd0, 16'h14, 16'h0, 16'h0, 32'h0, 3'd1, 300, lat);
    #1;
    chk("sat_lat", lat, 302);
    chk("sat_stall", stall, 8'd255);
    chk("sat_opa", opa, 32'd5);
    repeat (3) @(posedge CLK);
    #1;
    chk("sat_hold", stall, 8'd255);

    chk("write_queue_empty", exp_wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
